// File: rtl/vtiming_pkg.sv
// Shared timing record, standard modes and the legality rule for runtime configs.
package vtiming_pkg;

    localparam int VT_CW = 12;

    typedef struct packed {
        logic [VT_CW-1:0] h_active;
        logic [VT_CW-1:0] h_fp;
        logic [VT_CW-1:0] h_sync;
        logic [VT_CW-1:0] h_bp;
        logic [VT_CW-1:0] v_active;
        logic [VT_CW-1:0] v_fp;
        logic [VT_CW-1:0] v_sync;
        logic [VT_CW-1:0] v_bp;
        logic             h_pol;
        logic             v_pol;
    } vtiming_t;

    localparam vtiming_t VT_640x480_60 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam vtiming_t VT_800x600_60 = '{
        h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
        h_pol: 1'b1, v_pol: 1'b1};

    // Totals are summed two bits wider so four max-width fields cannot wrap.
    function automatic logic vtiming_legal(input vtiming_t t);
        logic [VT_CW+1:0] ht;
        logic [VT_CW+1:0] vt;
        logic [VT_CW+1:0] lim;
        logic             nz;
        lim = {2'b01, {VT_CW{1'b0}}};
        ht  = {2'b00, t.h_active} + {2'b00, t.h_fp} + {2'b00, t.h_sync} + {2'b00, t.h_bp};
        vt  = {2'b00, t.v_active} + {2'b00, t.v_fp} + {2'b00, t.v_sync} + {2'b00, t.v_bp};
        nz  = (t.h_active != '0) && (t.h_fp != '0) && (t.h_sync != '0) && (t.h_bp != '0) &&
              (t.v_active != '0) && (t.v_fp != '0) && (t.v_sync != '0) && (t.v_bp != '0);
        return nz && (ht <= lim) && (vt <= lim);
    endfunction

endpackage

// File: rtl/vtiming_span_cnt.sv
// One timing axis: wrapping position counter plus registered first/last/active/sync flags.
// Decode uses the next count and the config that applies to it; wrap uses the registered last flag.
module vtiming_span_cnt #(
    parameter int          CW      = 12,
    parameter logic [CW-1:0] RST_CNT = '0,
    parameter logic        RST_POL = 1'b0
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          en_i,
    input  logic [CW+1:0] tot_i,
    input  logic [CW+1:0] act_i,
    input  logic [CW+1:0] syn_lo_i,
    input  logic [CW+1:0] syn_hi_i,
    input  logic          pol_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o,
    output logic          first_o,
    output logic          act_o,
    output logic          syn_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW+1:0] cnt_w;
    logic          last_q, first_q, act_q, syn_q;

    assign cnt_d = !en_i ? cnt_q : (last_q ? '0 : cnt_q + 1'b1);
    assign cnt_w = {2'b00, cnt_d};

    // Reset parks the counter on its final position, so last starts high.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= RST_CNT;
            last_q  <= 1'b1;
            first_q <= 1'b0;
            act_q   <= 1'b0;
            syn_q   <= ~RST_POL;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= (cnt_w == tot_i - 1'b1);
            first_q <= (cnt_d == '0);
            act_q   <= (cnt_w < act_i);
            syn_q   <= ((cnt_w >= syn_lo_i) && (cnt_w < syn_hi_i)) ^ ~pol_i;
        end
    end

    assign cnt_o   = cnt_q;
    assign last_o  = last_q;
    assign first_o = first_q;
    assign act_o   = act_q;
    assign syn_o   = syn_q;

endmodule

// File: rtl/vtiming_gen.sv
// Video timing generator: sync/de/coords/strobes, all flops aligned to the same position.
// New configs are shadowed and swapped in on the (HT-1,VT-1)->(0,0) edge; cfg_ready low while one waits.
module vtiming_gen
    import vtiming_pkg::*;
#(
    parameter int   CW       = VT_CW,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_h_pol,
    input  logic          cfg_v_pol,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int HT0 = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT0 = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vtiming_t DEF_CFG = '{
        h_active: VT_CW'(H_ACTIVE), h_fp: VT_CW'(H_FP), h_sync: VT_CW'(H_SYNC), h_bp: VT_CW'(H_BP),
        v_active: VT_CW'(V_ACTIVE), v_fp: VT_CW'(V_FP), v_sync: VT_CW'(V_SYNC), v_bp: VT_CW'(V_BP),
        h_pol: H_POL, v_pol: V_POL};

    vtiming_t      cfg_in, cfg_act_q, cfg_pend_q, cfg_nx;
    logic          pend_vld_q, err_q;
    logic          x_last, y_last, x_first, y_first, h_act, v_act;
    logic          frame_end, apply, xfer, legal;
    logic [CW+1:0] h_slo, h_shi, h_tot, v_slo, v_shi, v_tot;

    assign cfg_in = '{
        h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
        v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
        h_pol: cfg_h_pol, v_pol: cfg_v_pol};

    assign legal     = vtiming_legal(cfg_in);
    assign frame_end = x_last & y_last;
    assign apply     = frame_end & pend_vld_q;
    // Ready reopens in the last cycle of a frame so a new offer can land on the swap edge.
    assign cfg_ready = ~pend_vld_q | frame_end;
    assign xfer      = cfg_valid & cfg_ready;
    assign cfg_nx    = apply ? cfg_pend_q : cfg_act_q;

    assign h_slo = {2'b00, cfg_nx.h_active} + {2'b00, cfg_nx.h_fp};
    assign h_shi = h_slo + {2'b00, cfg_nx.h_sync};
    assign h_tot = h_shi + {2'b00, cfg_nx.h_bp};
    assign v_slo = {2'b00, cfg_nx.v_active} + {2'b00, cfg_nx.v_fp};
    assign v_shi = v_slo + {2'b00, cfg_nx.v_sync};
    assign v_tot = v_shi + {2'b00, cfg_nx.v_bp};

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            cfg_act_q  <= DEF_CFG;
            cfg_pend_q <= DEF_CFG;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cfg_act_q <= cfg_nx;
            err_q     <= xfer & ~legal;
            if (xfer && legal) begin
                cfg_pend_q <= cfg_in;
                pend_vld_q <= 1'b1;
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    vtiming_span_cnt #(.CW(CW), .RST_CNT(CW'(HT0 - 1)), .RST_POL(H_POL)) u_h_cnt (
        .pixel_clock(pixel_clock), .reset(reset), .en_i(1'b1),
        .tot_i(h_tot), .act_i({2'b00, cfg_nx.h_active}), .syn_lo_i(h_slo), .syn_hi_i(h_shi),
        .pol_i(cfg_nx.h_pol),
        .cnt_o(x), .last_o(x_last), .first_o(x_first), .act_o(h_act), .syn_o(hsync)
    );

    vtiming_span_cnt #(.CW(CW), .RST_CNT(CW'(VT0 - 1)), .RST_POL(V_POL)) u_v_cnt (
        .pixel_clock(pixel_clock), .reset(reset), .en_i(x_last),
        .tot_i(v_tot), .act_i({2'b00, cfg_nx.v_active}), .syn_lo_i(v_slo), .syn_hi_i(v_shi),
        .pol_i(cfg_nx.v_pol),
        .cnt_o(y), .last_o(y_last), .first_o(y_first), .act_o(v_act), .syn_o(vsync)
    );

    assign de          = h_act & v_act;
    assign line_start  = x_first;
    assign frame_start = x_first & y_first;
    assign cfg_err     = err_q;

endmodule

// File: doc/vtiming_gen.md
Name: vtiming_gen

Overview:
- Parametrised video timing generator driven by pixel_clock.
- Produces hsync, vsync, data-enable, pixel/line coordinates and frame/line strobes for the TMDS/HDMI serialiser path.
- Timing and sync polarities are defaults at reset and can be reloaded at runtime through a valid/ready config port.
- A new config takes effect only at a frame boundary, so mode switches never produce a torn frame.

Parameters:
- CW, 12: coordinate/counter width; all cfg timing fields are CW bits.
- H_ACTIVE, 640: default horizontal active pixels.
- H_FP, 16: default horizontal front porch.
- H_SYNC, 96: default hsync width.
- H_BP, 48: default horizontal back porch.
- V_ACTIVE, 480: default active lines.
- V_FP, 10: default vertical front porch.
- V_SYNC, 2: default vsync width.
- V_BP, 33: default vertical back porch.
- H_POL, 0: default hsync polarity (1 = active-high).
- V_POL, 0: default vsync polarity (1 = active-high).

Ports:
- pixel_clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  new timing offered
- cfg_ready  out  1  no config pending
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  horizontal fields
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  vertical fields
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarities
- cfg_err  out  1  one-cycle pulse: offered config rejected
- hsync  out  1  polarity-applied horizontal sync
- vsync  out  1  polarity-applied vertical sync
- de  out  1  active video
- x  out  CW  current pixel column
- y  out  CW  current line
- line_start  out  1  pulse when x==0
- frame_start  out  1  pulse when x==0 and y==0

Behaviour:
- Definitions: HT = h_active+h_fp+h_sync+h_bp; VT = same sum over the v fields.
- All outputs are registered and describe the same position (x, y) in the same cycle. There is no skew between de, sync, strobes and coordinates.
- x counts 0..HT-1, then wraps to 0. y increments on each x wrap and wraps VT-1 -> 0.
- Decode (on the active, i.e. currently applied, config):
  - de = (x < h_active) and (y < v_active).
  - hsync asserted iff h_active+h_fp <= x < h_active+h_fp+h_sync.
  - vsync asserted iff v_active+v_fp <= y < v_active+v_fp+v_sync; vsync changes only at x==0.
  - Polarity: output = asserted XOR (not pol).
- Reset (asynchronous):
  - Active config = parameter defaults; pending config cleared.
  - x = HT-1, y = VT-1.
  - de = 0, line_start = 0, frame_start = 0, cfg_err = 0, cfg_ready = 1.
  - hsync/vsync at their inactive levels (for defaults: hsync = 1, vsync = 1).
  - First edge after release: x = 0, y = 0, de = 1, line_start = 1, frame_start = 1.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready on a rising edge.
  - Legality check: every field >= 1, and HT and VT each <= 2^CW. The sums are computed at CW+2 bits.
  - Legal config: latched into the pending shadow; cfg_ready drops on the next cycle.
  - Illegal config: dropped; cfg_err = 1 for exactly one cycle; cfg_ready stays 1.
- Apply: on the edge where the position advances from (HT-1, VT-1) to (0, 0), the pending config becomes active and is used for that cycle's decode. cfg_ready returns to 1 on the same edge.
- Transfer on the apply edge: the current pending config is applied; the new one becomes pending and applies at the following frame boundary.
- Reset mid-frame or mid-handshake: pending config discarded; defaults restored; restart as above.
- No other path changes the active config; x and y never exceed HT-1 / VT-1.

Decomposition:
- Package vtiming_pkg holds:
  - typedef vtiming_t (the eight CW-bit fields plus two polarity bits);
  - constants VT_640x480_60 and VT_800x600_60;
  - function vtiming_legal() implementing the legality check.
- Sub-module vtiming_span_cnt, instantiated once for the horizontal axis and once for the vertical axis:
  - counter with enable, wrap at the total, and registered active/sync phase decode.

Test Plan:
- Reset release with defaults -> first edge x=0, y=0, de=1, frame_start=1. Next frame_start exactly 420000 cycles later; line_start period 800 cycles.
- Default line -> de high for x 0..639; hsync low for x 656..751 and high elsewhere. vsync low only for y 490..491; de=0 for all y >= 480.
- Mid-frame load of 800x600 timing (40/128/88, 1/4/23, pol 1/1) -> cfg_ready=0 until the next frame boundary, timing unchanged until then. From that boundary: HT=1056, VT=628, hsync high for x 840..967.
- Illegal config (cfg_h_sync=0) -> cfg_err one-cycle pulse, cfg_ready stays 1, timing unchanged.
- Config transferred on the apply edge -> previously pending config applied at that edge; new config applied one full frame later.
- Reset asserted mid-frame with a config pending -> outputs return to their reset values; after release, default timing resumes and the pending config never appears.
